// File: rtl/wb_cfg_loader_pkg.sv
// Shared constants and types for the Wishbone configuration loader.
// Register offsets, chain length and FSM encoding.
package wb_cfg_loader_pkg;

  localparam int CFG_SIZE = 40;

  localparam logic [3:0] CFG_LD_DATA   = 4'h0;
  localparam logic [3:0] CFG_LD_CTRL   = 4'h4;
  localparam logic [3:0] CFG_LD_STATUS = 4'h8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_cfg_loader_slave_if.sv
// Wishbone slave front end: decode, ack/stall and registered read mux.
// Hands accepted DATA writes and clr requests to the loader core.
module wb_slave_if
  import wb_cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        i_busy,
  input  logic        i_buf_full,
  input  logic        i_done,
  input  logic [15:0] i_words_loaded,
  output logic        o_wr_data_valid,
  output logic [31:0] o_wr_data,
  output logic        o_clr_pulse
);

  logic        w_hit;
  logic        w_is_data;
  logic        w_is_ctrl;
  logic        w_is_stat;
  logic        w_stall;
  logic        w_acc;
  logic        w_unused;
  logic        r_ack;
  logic [31:0] r_dat;
  logic [31:0] w_status;

  assign w_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

  always_comb begin
    w_is_data = 1'b0;
    w_is_ctrl = 1'b0;
    w_is_stat = 1'b0;
    unique case (1'b1)
      (wbs_adr_i[3:0] == CFG_LD_DATA):   w_is_data = 1'b1;
      (wbs_adr_i[3:0] == CFG_LD_CTRL):   w_is_ctrl = 1'b1;
      (wbs_adr_i[3:0] == CFG_LD_STATUS): w_is_stat = 1'b1;
      default: ;
    endcase
  end

  // Only a DATA write into a full buffer waits; everything else goes at once.
  assign w_stall = w_is_data & wbs_we_i & i_buf_full;
  assign w_acc   = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack & ~w_stall;

  assign o_wr_data_valid = w_acc & wbs_we_i & w_is_data;
  assign o_wr_data       = wbs_dat_i;
  assign o_clr_pulse     = w_acc & wbs_we_i & w_is_ctrl & wbs_dat_i[0];

  assign w_status = {i_words_loaded, 13'd0, i_done, i_buf_full, i_busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~wbs_we_i & w_is_stat) ? w_status : '0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  assign w_unused = &{1'b0, wbs_sel_i};

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone-fed serializer for the fabric configuration shift chain.
// Words are shifted LSB-first, one bit per clock, until CFG_SIZE bits.
module wb_cfg_loader
  import wb_cfg_loader_pkg::*;
#(
  parameter int          CFG_SIZE  = wb_cfg_loader_pkg::CFG_SIZE,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
)(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_bit_o,
  output logic        cfg_shift_en_o,
  output logic        cfg_done_o
);

  localparam int BW = $clog2(CFG_SIZE + 1);

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_shreg, w_shreg_nxt;
  logic [31:0]   r_buf, w_buf_nxt;
  logic          r_buf_full, w_buf_full_nxt;
  logic [4:0]    r_word_cnt, w_word_cnt_nxt;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic          r_done, w_done_nxt;
  logic [15:0]   r_words, w_words_nxt;
  logic          r_en, w_en_nxt;
  logic          r_bit, w_bit_nxt;
  logic          w_wr_valid;
  logic [31:0]   w_wr_data;
  logic          w_clr;
  logic          w_busy;

  assign w_busy = (r_state == ST_SHIFT);

  wb_slave_if #(
    .BASE_ADDR (BASE_ADDR)
  ) u_wb (
    .clk             (wb_clk_i),
    .rst_n           (wb_rst_ni),
    .wbs_stb_i       (wbs_stb_i),
    .wbs_cyc_i       (wbs_cyc_i),
    .wbs_we_i        (wbs_we_i),
    .wbs_sel_i       (wbs_sel_i),
    .wbs_adr_i       (wbs_adr_i),
    .wbs_dat_i       (wbs_dat_i),
    .wbs_ack_o       (wbs_ack_o),
    .wbs_dat_o       (wbs_dat_o),
    .i_busy          (w_busy),
    .i_buf_full      (r_buf_full),
    .i_done          (r_done),
    .i_words_loaded  (r_words),
    .o_wr_data_valid (w_wr_valid),
    .o_wr_data       (w_wr_data),
    .o_clr_pulse     (w_clr)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    w_word_cnt_nxt = r_word_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_done_nxt     = r_done;
    w_words_nxt    = r_words;

    // Writes after completion are acked but dropped.
    if (w_wr_valid && !r_done) begin
      w_buf_nxt      = w_wr_data;
      w_buf_full_nxt = 1'b1;
      w_words_nxt    = sat_inc16(r_words);
    end

    unique case (r_state)
      ST_IDLE: begin
        if (r_buf_full && !r_done) begin
          w_shreg_nxt    = r_buf;
          w_buf_full_nxt = 1'b0;
          w_word_cnt_nxt = 5'd0;
          w_state_nxt    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shreg_nxt    = r_shreg >> 1;
        w_word_cnt_nxt = r_word_cnt + 5'd1;
        w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
        if (r_bit_cnt == BW'(CFG_SIZE - 1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_word_cnt == 5'd31 && r_buf_full) begin
          w_shreg_nxt    = r_buf;
          w_buf_full_nxt = 1'b0;
          w_word_cnt_nxt = 5'd0;
        end else if (r_word_cnt == 5'd31) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_clr) begin
      w_state_nxt    = ST_IDLE;
      w_buf_full_nxt = 1'b0;
      w_word_cnt_nxt = 5'd0;
      w_bit_cnt_nxt  = '0;
      w_done_nxt     = 1'b0;
      w_words_nxt    = 16'd0;
    end

    // Chain outputs are flopped copies of the next shift state.
    w_en_nxt  = (w_state_nxt == ST_SHIFT);
    w_bit_nxt = w_en_nxt & w_shreg_nxt[0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_done     <= 1'b0;
      r_words    <= '0;
      r_en       <= 1'b0;
      r_bit      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_done     <= w_done_nxt;
      r_words    <= w_words_nxt;
      r_en       <= w_en_nxt;
      r_bit      <= w_bit_nxt;
    end
  end

  assign cfg_shift_en_o = r_en;
  assign cfg_bit_o      = r_bit;
  assign cfg_done_o     = r_done;

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Self-checking bench for wb_cfg_loader with a 40-bit chain.
// Expected bit streams come from a queue model of the accepted words.
module tb_wb_cfg_loader;

  localparam int          CFG  = 40;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_UNM  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cbit;
  logic        cen;
  logic        cdone;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt = 0;

  bit cap_bits[$];
  int cap_cyc[$];
  bit exp_bits[$];
  int done_rise = -1;
  logic prev_done = 1'b0;

  wb_cfg_loader #(
    .CFG_SIZE  (CFG),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .wbs_stb_i      (stb),
    .wbs_cyc_i      (cyc),
    .wbs_we_i       (we),
    .wbs_sel_i      (sel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (dat),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (rdat),
    .cfg_bit_o      (cbit),
    .cfg_shift_en_o (cen),
    .cfg_done_o     (cdone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (cen) begin
      cap_bits.push_back(cbit);
      cap_cyc.push_back(cyc_cnt);
    end
    if (cdone && !prev_done) done_rise = cyc_cnt;
    prev_done = cdone;
  end

  // Model: the chain sees accepted words LSB-first, cut off at CFG bits.
  function automatic void model_push(input logic [31:0] w);
    for (int i = 0; i < 32; i++)
      if (exp_bits.size() < CFG) exp_bits.push_back(w[i]);
  endfunction

  function automatic int first_diff();
    if (cap_bits.size() < exp_bits.size()) return cap_bits.size();
    foreach (exp_bits[i])
      if (cap_bits[i] !== exp_bits[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] status_word(
    input int words, input bit done, input bit full, input bit busy
  );
    return {16'(words), 13'd0, done, full, busy};
  endfunction

  function automatic void clear_caps();
    cap_bits.delete();
    cap_cyc.delete();
    exp_bits.delete();
    done_rise = -1;
  endfunction

  // Must be called between edges; returns at the negedge where ack is seen.
  task automatic bus(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [31:0] d,
    input  int          budget,
    output logic [31:0] rd,
    output int          ack_at,
    output int          waited,
    output bit          ok
  );
    stb = 1'b1;
    cyc = 1'b1;
    we  = w;
    adr = a;
    dat = d;
    sel = 4'($urandom);
    ok = 1'b0;
    rd = '0;
    ack_at = -1;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (ack) begin
        ok = 1'b1;
        ack_at = cyc_cnt;
        rd = rdat;
        break;
      end
    end
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cdone) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic do_clr();
    logic [31:0] r;
    int a, wt;
    bit ok;
    bus(A_CTRL, 1'b1, 32'h1, 10, r, a, wt, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL clr_ack: no ack within 10 cycles, required ack");
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int a, wt;
    bit ok;
    #13;
    n_checks++;
    if ({cen, cbit, cdone, ack, rdat} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_outs: got en=%b bit=%b done=%b ack=%b dat=%h, required all 0", cen, cbit, cdone, ack, rdat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus(A_STAT, 1'b0, 32'h0, 10, r, a, wt, ok);
    n_checks++;
    if (!ok || wt != 1) begin
      n_errors++;
      $display("FAIL reset_ack_lat: got ok=%0d wait=%0d, required ok=1 wait=1", ok, wt);
    end
    n_checks++;
    if (r !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_status: got %h, required 00000000", r);
    end
    n_checks++;
    if (cen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_en: got %b, required 0", cen);
    end
  endtask

  task automatic test_stream();
    logic [31:0] r;
    int a1, a2, wt, d;
    bit ok1, ok2, okd;
    clear_caps();
    model_push(32'hA5A5A5A5);
    model_push(32'h000000FF);
    bus(A_DATA, 1'b1, 32'hA5A5A5A5, 10, r, a1, wt, ok1);
    bus(A_DATA, 1'b1, 32'h000000FF, 10, r, a2, wt, ok2);
    wait_done(okd);
    n_checks++;
    if (!ok1 || !ok2 || !okd) begin
      n_errors++;
      $display("FAIL stream_acks: got ack1=%0d ack2=%0d done=%0d, required 1 1 1", ok1, ok2, okd);
    end
    n_checks++;
    if (cap_bits.size() != CFG) begin
      n_errors++;
      $display("FAIL stream_count: got %0d pulses, required %0d", cap_bits.size(), CFG);
    end else begin
      n_checks++;
      if (cap_cyc[0] != a1 + 1) begin
        n_errors++;
        $display("FAIL stream_first: got cycle %0d, required %0d", cap_cyc[0], a1 + 1);
      end
      n_checks++;
      if (cap_cyc[CFG-1] - cap_cyc[0] != CFG - 1) begin
        n_errors++;
        $display("FAIL stream_gap: got span %0d, required %0d", cap_cyc[CFG-1] - cap_cyc[0], CFG - 1);
      end
      n_checks++;
      if (done_rise != cap_cyc[CFG-1] + 1) begin
        n_errors++;
        $display("FAIL stream_done_rise: got cycle %0d, required %0d", done_rise, cap_cyc[CFG-1] + 1);
      end
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_errors++;
      $display("FAIL stream_bits: got mismatch at bit %0d, required none", d);
    end
    bus(A_STAT, 1'b0, 32'h0, 10, r, a1, wt, ok1);
    n_checks++;
    if (r !== 32'h0002_0004) begin
      n_errors++;
      $display("FAIL stream_status: got %h, required 00020004", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [31:0] w[3];
    int at[3];
    int wt, d;
    bit ok[3];
    bit okd;
    do_clr();
    clear_caps();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      model_push(w[i]);
    end
    for (int i = 0; i < 3; i++)
      bus(A_DATA, 1'b1, w[i], 60, r, at[i], wt, ok[i]);
    wait_done(okd);
    n_checks++;
    if (!(ok[0] && ok[1] && ok[2] && okd)) begin
      n_errors++;
      $display("FAIL b2b_acks: got %0d%0d%0d done=%0d, required 111 done=1", ok[0], ok[1], ok[2], okd);
    end
    // Third word waits for the first word's last bit to free the buffer.
    n_checks++;
    if (at[2] - at[0] != 34) begin
      n_errors++;
      $display("FAIL b2b_stall: got ack3-ack1=%0d, required 34", at[2] - at[0]);
    end
    n_checks++;
    if (cap_bits.size() != CFG || cap_cyc[CFG-1] - cap_cyc[0] != CFG - 1) begin
      n_errors++;
      $display("FAIL b2b_contig: got %0d pulses, required %0d contiguous", cap_bits.size(), CFG);
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_errors++;
      $display("FAIL b2b_bits: got mismatch at bit %0d, required none", d);
    end
    bus(A_STAT, 1'b0, 32'h0, 10, r, wt, wt, okd);
    n_checks++;
    if (r !== status_word(3, 1, 1, 0)) begin
      n_errors++;
      $display("FAIL b2b_status: got %h, required %h", r, status_word(3, 1, 1, 0));
    end
  endtask

  task automatic test_clr();
    logic [31:0] r, w0, w1, w2;
    int a, wt, d;
    bit ok, okd;
    do_clr();
    clear_caps();
    w0 = $urandom;
    w1 = $urandom;
    w2 = $urandom;
    bus(A_DATA, 1'b1, w0, 10, r, a, wt, ok);
    okd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (cap_bits.size() == 10) begin
        okd = 1'b1;
        break;
      end
    end
    bus(A_CTRL, 1'b1, {$urandom} | 32'h1, 10, r, a, wt, ok);
    #1;
    n_checks++;
    if (!okd || !ok || cen !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_stop: got reached10=%0d ack=%0d en=%b, required 1 1 0", okd, ok, cen);
    end
    repeat (5) @(negedge clk);
    #1;
    for (int i = 0; i < 10; i++) exp_bits.push_back(w0[i]);
    d = first_diff();
    n_checks++;
    if (cap_bits.size() != 10 || d != -1) begin
      n_errors++;
      $display("FAIL clr_bits: got %0d pulses diff=%0d, required 10 pulses diff=-1", cap_bits.size(), d);
    end
    bus(A_STAT, 1'b0, 32'h0, 10, r, a, wt, ok);
    n_checks++;
    if (r !== 32'h0) begin
      n_errors++;
      $display("FAIL clr_status: got %h, required 00000000", r);
    end
    clear_caps();
    model_push(w1);
    model_push(w2);
    bus(A_DATA, 1'b1, w1, 10, r, a, wt, ok);
    bus(A_DATA, 1'b1, w2, 60, r, a, wt, ok);
    wait_done(okd);
    d = first_diff();
    n_checks++;
    if (!okd || cap_bits.size() != CFG || d != -1) begin
      n_errors++;
      $display("FAIL clr_restart: got done=%0d pulses=%0d diff=%0d, required 1 %0d -1", okd, cap_bits.size(), CFG, d);
    end
  endtask

  task automatic test_after_done();
    logic [31:0] r;
    int a, wt;
    bit ok;
    clear_caps();
    bus(A_DATA, 1'b1, 32'hFFFFFFFF, 10, r, a, wt, ok);
    repeat (50) @(negedge clk);
    #1;
    n_checks++;
    if (!ok || cap_bits.size() != 0) begin
      n_errors++;
      $display("FAIL done_discard: got ack=%0d pulses=%0d, required 1 0", ok, cap_bits.size());
    end
    bus(A_STAT, 1'b0, 32'h0, 10, r, a, wt, ok);
    n_checks++;
    if (r !== 32'h0002_0004) begin
      n_errors++;
      $display("FAIL done_status: got %h, required 00020004", r);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, w0, w1;
    int a, wt, d, gap;
    bit ok, okd;
    for (int it = 0; it < 6; it++) begin
      do_clr();
      clear_caps();
      w0 = $urandom;
      w1 = $urandom;
      model_push(w0);
      model_push(w1);
      bus(A_DATA, 1'b1, w0, 10, r, a, wt, ok);
      gap = $urandom_range(0, 40);
      repeat (gap) @(negedge clk);
      bus((it % 2) ? A_STAT : A_UNM, 1'b1, $urandom, 10, r, a, wt, ok);
      bus(A_DATA, 1'b0, 32'h0, 10, r, a, wt, ok);
      n_checks++;
      if (!ok || r !== 32'h0) begin
        n_errors++;
        $display("FAIL rnd_data_read: got ack=%0d dat=%h, required 1 00000000", ok, r);
      end
      bus(BASE + 32'h10 + {26'd0, 6'($urandom)}, 1'b1, $urandom, 8, r, a, wt, ok);
      n_checks++;
      if (ok) begin
        n_errors++;
        $display("FAIL rnd_miss_addr: got ack, required none");
      end
      bus(A_DATA, 1'b1, w1, 60, r, a, wt, ok);
      wait_done(okd);
      d = first_diff();
      n_checks++;
      if (!okd || cap_bits.size() != CFG || d != -1) begin
        n_errors++;
        $display("FAIL rnd_stream it%0d: got done=%0d pulses=%0d diff=%0d, required 1 %0d -1", it, okd, cap_bits.size(), CFG, d);
      end
      bus(A_STAT, 1'b0, 32'h0, 10, r, a, wt, ok);
      n_checks++;
      if (r !== 32'h0002_0004) begin
        n_errors++;
        $display("FAIL rnd_status it%0d: got %h, required 00020004", it, r);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int a, wt, n;
    bit ok, okw;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cdone !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_done: got %b, required 0", cdone);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_caps();
    bus(A_DATA, 1'b1, $urandom, 10, r, a, wt, ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (cap_bits.size() >= 5) break;
    end
    stb = 1'b1;
    cyc = 1'b1;
    we  = 1'b1;
    adr = A_DATA;
    dat = $urandom;
    okw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) begin
        okw = 1'b1;
        break;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!okw || cen !== 1'b0 || ack !== 1'b0 || cbit !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_mid: got ackseen=%0d en=%b ack=%b bit=%b, required 1 0 0 0", okw, cen, ack, cbit);
    end
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = cap_bits.size();
    repeat (40) @(negedge clk);
    #1;
    n_checks++;
    if (cap_bits.size() != n) begin
      n_errors++;
      $display("FAIL arst_quiet: got %0d pulses after reset, required 0", cap_bits.size() - n);
    end
    bus(A_UNM, 1'b0, 32'h0, 10, r, a, wt, ok);
    n_checks++;
    if (!ok || wt != 1 || r !== 32'h0) begin
      n_errors++;
      $display("FAIL unmapped_read: got ack=%0d wait=%0d dat=%h, required 1 1 00000000", ok, wt, r);
    end
    bus(A_STAT, 1'b0, 32'h0, 10, r, a, wt, ok);
    n_checks++;
    if (r !== 32'h0) begin
      n_errors++;
      $display("FAIL arst_status: got %h, required 00000000", r);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_clr();
    test_after_done();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
